mult_div_ctrl: RTL and testbench
================================

Name: mult_div_ctrl

Overview:
Multicycle sequencer for the signed MULT/DIV path that feeds the HI/LO registers of the multicycle MIPS CPU. The main controller issues a one-cycle start with the operation and both operands (RegA/RegB). The block then runs a 32-step radix-2 Booth multiply or a restoring signed divide, loads HI/LO, and pulses done. It owns HI/LO, drives the HI/LO inputs of the MemtoReg mux, and flags divide-by-zero so the controller can raise the exception.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle request, sampled only in IDLE.
op  in  1  0 = MULT, 1 = DIV.
a  in  DATA_W  signed multiplicand / dividend (RegA).
b  in  DATA_W  signed multiplier / divisor (RegB).
busy  out  1  high from the edge after start is accepted until done/div_zero is issued.
done  out  1  one-cycle pulse; HI/LO valid and updated.
div_zero  out  1  one-cycle pulse; DIV with b == 0, HI/LO unchanged.
hi  out  DATA_W  HI register.
lo  out  DATA_W  LO register.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, iteration counter = 0.
- States: IDLE, MULT, DIV, FIX, FIN.
- IDLE:
  - start & op = 0 → MULT. Latch a and b; clear partial product; counter = 0.
  - start & op = 1 & b ≠ 0 → DIV. Latch |a| and |b|, sign(a), sign(a) ^ sign(b); clear remainder; counter = 0.
  - start & op = 1 & b = 0 → FIN with div_zero flag set; no iterations.
- MULT: one Booth step per cycle (examine multiplier bits [0] and the prior bit; add/sub/none; arithmetic shift right of a 2·DATA_W+1 accumulator). At counter = DATA_W−1 → FIX.
- DIV: one restoring step per cycle (shift remainder/quotient left; trial subtract; restore if negative). At counter = DATA_W−1 → FIX.
- FIX: load outputs, then → FIN.
  - MULT: {hi, lo} = 64-bit two's-complement product.
  - DIV: lo = quotient negated if signs differ; hi = remainder negated if dividend negative. Quotient truncates toward zero; remainder takes the dividend's sign.
- FIN: done = 1 (or div_zero = 1 for the zero case, with done = 0). → IDLE next edge.
- Latency: start sampled at edge E0; iterations at E1..E32; HI/LO loaded at E33; done high during the cycle after E34, i.e. 34 cycles after the start edge. Divide-by-zero pulses one cycle after the start edge.
- busy: high in MULT/DIV/FIX, low in IDLE/FIN.
- start while not IDLE: ignored, with no queueing and no effect on the running operation.
- start in FIN: ignored; the controller must re-issue it in IDLE.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (natural wrap, no flag).
- MULT never overflows. Both operand signs handled by Booth.
- hi/lo hold their values between operations and are readable at any time, including while busy (stale value).
- Reset asserted mid-operation: immediately IDLE; hi/lo cleared; no done pulse.
- Operands are latched at acceptance; changes to a/b afterwards have no effect.

Decomposition:
- Shared package: state encoding (IDLE, MULT, DIV, FIX, FIN), op codes OP_MULT = 1'b0 and OP_DIV = 1'b1, and the DATA_W default. The main controladora uses the op codes when decoding funct 0x18/0x1A.
- One natural sub-module: mult_div_datapath, holding the accumulator, remainder/quotient shift registers and adder/subtractor with per-step enables. mult_div_ctrl keeps the FSM, counter and HI/LO registers.

Test Plan:
- MULT a = 7, b = −3 → done exactly 34 cycles after the start edge; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high in between.
- MULT a = b = 0x80000000 → hi = 0x40000000, lo = 0x00000000.
- DIV a = −7, b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV a = 0x80000000, b = −1 → lo = 0x80000000, hi = 0.
- DIV with b = 0 after a prior result hi = 0x11, lo = 0x22 → div_zero pulses one cycle after start, done stays 0, hi/lo still 0x11/0x22, busy never high.
- Start a MULT 7 × 3, then pulse start with DIV 100/0 at cycle 10 → second start ignored, no div_zero; result hi = 0, lo = 21.
- Assert rst low at cycle 15 of a DIV → hi = lo = 0, busy = 0, no done; a new MULT 2 × 2 after release gives lo = 4.

Source files
------------

// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// The main controller also uses OP_MULT/OP_DIV when decoding funct 0x18/0x1A.
package mult_div_ctrl_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FIX,
        ST_FIN
    } state_e;

    function automatic logic state_is_busy(state_e s);
        return (s == ST_MULT) || (s == ST_DIV) || (s == ST_FIX);
    endfunction

endpackage

// File: rtl/mult_div_datapath.sv
// Booth multiply accumulator and restoring-divide remainder/quotient registers.
// Each operation is loaded with load_* and then advanced one step per step_* cycle.
module mult_div_datapath
    import mult_div_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_mult,
    input  logic                  load_div,
    input  logic                  step_mult,
    input  logic                  step_div,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   product,
    output logic [DATA_W-1:0]     quotient,
    output logic [DATA_W-1:0]     remainder
);

    localparam int ACC_W = 2 * DATA_W + 1;

    // acc = {partial product, multiplier, previous multiplier bit}
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] dvsr_q, dvsr_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;

    logic [DATA_W:0] pp_ext;
    logic [DATA_W:0] mcand_ext;
    logic [DATA_W:0] booth_sum;
    logic [DATA_W:0] div_shift;
    logic [DATA_W:0] div_trial;

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        dvsr_d  = dvsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;

        // One guard bit keeps the add/sub exact even for a multiplicand of -2^(DATA_W-1).
        pp_ext    = {acc_q[ACC_W-1], acc_q[ACC_W-1 -: DATA_W]};
        mcand_ext = {mcand_q[DATA_W-1], mcand_q};
        case (acc_q[1:0])
            2'b01:   booth_sum = pp_ext + mcand_ext;
            2'b10:   booth_sum = pp_ext - mcand_ext;
            default: booth_sum = pp_ext;
        endcase

        div_shift = {rem_q, quo_q[DATA_W-1]};
        div_trial = div_shift - {1'b0, dvsr_q};

        if (load_mult) begin
            acc_d   = {{DATA_W{1'b0}}, b, 1'b0};
            mcand_d = a;
        end else if (load_div) begin
            rem_d  = '0;
            quo_d  = a[DATA_W-1] ? -a : a;
            dvsr_d = b[DATA_W-1] ? -b : b;
        end else if (step_mult) begin
            acc_d = {booth_sum, acc_q[DATA_W:1]};
        end else if (step_div) begin
            rem_d = div_trial[DATA_W] ? div_shift[DATA_W-1:0] : div_trial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], ~div_trial[DATA_W]};
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments; the
    // working registers are reset too so no X ever reaches HI/LO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            dvsr_q  <= dvsr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

    assign product   = acc_q[ACC_W-1:1];
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mult_div_ctrl.sv
// MULT/DIV sequencer owning HI/LO: accepts a start in IDLE, iterates DATA_W steps,
// applies sign fix-up, then pulses done (or div_zero for a zero divisor).
module mult_div_ctrl
    import mult_div_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              done_q, done_d;
    logic              div_zero_q, div_zero_d;

    logic                load_mult, load_div, step_mult, step_div;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   quotient, remainder;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        zero_d     = zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        load_mult  = 1'b0;
        load_div   = 1'b0;
        step_mult  = 1'b0;
        step_div   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op;
                    cnt_d  = '0;
                    zero_d = 1'b0;
                    if (op == OP_MULT) begin
                        load_mult = 1'b1;
                        state_d   = ST_MULT;
                    end else if (b == '0) begin
                        zero_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        load_div  = 1'b1;
                        neg_quo_d = a[DATA_W-1] ^ b[DATA_W-1];
                        neg_rem_d = a[DATA_W-1];
                        state_d   = ST_DIV;
                    end
                end
            end
            ST_MULT, ST_DIV: begin
                step_mult = (state_q == ST_MULT);
                step_div  = (state_q == ST_DIV);
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (op_q == OP_MULT) begin
                    {hi_d, lo_d} = product;
                end else begin
                    lo_d = neg_quo_q ? -quotient : quotient;
                    hi_d = neg_rem_q ? -remainder : remainder;
                end
                state_d = ST_FIN;
            end
            ST_FIN: begin
                done_d     = ~zero_q;
                div_zero_d = zero_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_MULT;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            zero_q     <= zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    mult_div_datapath #(
        .DATA_W (DATA_W)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load_mult (load_mult),
        .load_div  (load_div),
        .step_mult (step_mult),
        .step_div  (step_div),
        .a         (a),
        .b         (b),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    assign busy     = state_is_busy(state_q);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed vector table, corner sequences,
// and randomized operations compared against a plain-arithmetic reference model.
module tb_mult_div_ctrl;
    import mult_div_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    always #5 clk = ~clk;

    mult_div_ctrl #(.DATA_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } res_t;

    typedef struct {
        logic         o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           inj;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // HI/LO semantics straight from signed 64-bit arithmetic.
    function automatic res_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] prev_hi, input logic [W-1:0] prev_lo);
        res_t   r;
        longint sx, sy, p, q, rm;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.dz = 1'b0;
        if (o == OP_MULT) begin
            p    = sx * sy;
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (y == '0) begin
            r.hi = prev_hi;
            r.lo = prev_lo;
            r.dz = 1'b1;
        end else begin
            q    = sx / sy;
            rm   = sx % sy;
            r.hi = rm[31:0];
            r.lo = q[31:0];
        end
        return r;
    endfunction

    // Issues one operation, watches 40 cycles after the start edge, checks timing and HI/LO.
    // k counts negedges after the start edge: k = 0 lies between E0 and E1.
    task automatic run_op(input string name, input logic o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int inj,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input logic e_dz);
        int done_k   = -1;
        int dz_k     = -1;
        int pulses   = 0;
        int busy_err = 0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (done_k < 0) done_k = k;
            end
            if (div_zero) begin
                pulses++;
                if (dz_k < 0) dz_k = k;
            end
            if (busy !== (!e_dz && k <= 32)) busy_err++;
            if (k == inj) begin
                start = 1'b1;
                op    = OP_DIV;
                a     = 100;
                b     = 0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check({name, " done_cycle"}, 64'(done_k), e_dz ? 64'(-1) : 64'(34));
        check({name, " dz_cycle"},   64'(dz_k),   e_dz ? 64'(1)  : 64'(-1));
        check({name, " pulses"},     64'(pulses), 64'(1));
        check({name, " busy_errs"},  64'(busy_err), 64'(0));
        check({name, " hi"}, 64'(hi), 64'(e_hi));
        check({name, " lo"}, 64'(lo), 64'(e_lo));
        exp_hi = e_hi;
        exp_lo = e_lo;
    endtask

    vec_t vecs[7];

    initial begin
        res_t         e;
        logic         ro;
        logic [W-1:0] rx, ry;

        vecs[0] = '{OP_MULT, 32'd7,        -32'sd3,      -1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{OP_MULT, 32'h8000_0000, 32'h8000_0000, -1, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[2] = '{OP_DIV,  -32'sd7,      32'd2,        -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{OP_DIV,  32'd697,      32'd20,       -1, 32'h0000_0011, 32'h0000_0022, 1'b0};
        vecs[5] = '{OP_DIV,  32'd5,        32'd0,        -1, 32'h0000_0011, 32'h0000_0022, 1'b1};
        vecs[6] = '{OP_MULT, 32'd7,        32'd3,        10, 32'h0000_0000, 32'h0000_0015, 1'b0};

        rst   = 1'b0;
        start = 1'b0;
        op    = OP_MULT;
        a     = '0;
        b     = '0;
        #12;
        check("reset hi",       64'(hi),       64'(0));
        check("reset lo",       64'(lo),       64'(0));
        check("reset busy",     64'(busy),     64'(0));
        check("reset done",     64'(done),     64'(0));
        check("reset div_zero", 64'(div_zero), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].inj,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz);
        end

        // Reset in the middle of a divide: HI/LO cleared, no done, then a fresh MULT works.
        @(negedge clk);
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd1000;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("midreset busy_before", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        check("midreset hi",   64'(hi),   64'(0));
        check("midreset lo",   64'(lo),   64'(0));
        check("midreset busy", 64'(busy), 64'(0));
        begin
            int seen = 0;
            for (int k = 0; k < 25; k++) begin
                @(negedge clk);
                if (done || div_zero) seen++;
                if (k == 2) rst = 1'b1;
            end
            check("midreset no_done", 64'(seen), 64'(0));
        end
        exp_hi = '0;
        exp_lo = '0;
        run_op("post_reset_mult", OP_MULT, 32'd2, 32'd2, -1, 32'd0, 32'd4, 1'b0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 24; n++) begin
            ro = 1'($urandom);
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0:       ry = '0;
                1:       ry = W'($urandom_range(1, 15));
                2:       rx = 32'h8000_0000;
                3:       ry = 32'hFFFF_FFFF;
                default: ;
            endcase
            e = model(ro, rx, ry, exp_hi, exp_lo);
            run_op($sformatf("rnd%0d", n), ro, rx, ry, -1, e.hi, e.lo, e.dz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
